// File: rtl/srload_pkg.sv
// srload_pkg: shared state encoding, default register sizes and width helpers for the serial loader
package srload_pkg;
  typedef enum logic [2:0] {IDLE, SH_STAT, LAT_STAT, SH_DYN, LAT_DYN, FIN} state_t;
  localparam int DEF_SIZESRSTAT = 88;
  localparam int DEF_SIZESRDYN = 16;
  localparam int DEF_CLKDIV = 4;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/shiftreg_loader_if.sv
// shiftreg_loader_if: request/word inputs and serial/select/latch outputs of the loader
interface shiftreg_loader_if
  import srload_pkg::*;
#(
  parameter int SIZESRSTAT = DEF_SIZESRSTAT,
  parameter int SIZESRDYN = DEF_SIZESRDYN
);
  logic START;
  logic [SIZESRSTAT-1:0] STAT_WORD;
  logic [SIZESRDYN-1:0] DYN_WORD;
  logic SDATA;
  logic SHIFT;
  logic SELSTAT;
  logic SELDYN;
  logic LATCH_STAT;
  logic LATCH_DYN;
  logic BUSY;
  logic DONE;
  modport master (
    output START, STAT_WORD, DYN_WORD,
    input SDATA, SHIFT, SELSTAT, SELDYN, LATCH_STAT, LATCH_DYN, BUSY, DONE
  );
  modport slave (
    input START, STAT_WORD, DYN_WORD,
    output SDATA, SHIFT, SELSTAT, SELDYN, LATCH_STAT, LATCH_DYN, BUSY, DONE
  );
endinterface

// File: rtl/srload_serializer.sv
// srload_serializer: parallel-in MSB-first serial-out with bit-period divider and shift strobe
module srload_serializer
  import srload_pkg::*;
#(
  parameter int W = 8,
  parameter int CLKDIV = 2,
  parameter int BW = cw(W)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          load_i,
  input  logic [W-1:0]  data_i,
  input  logic [BW-1:0] top_i,
  input  logic          en_i,
  output logic          sdata_o,
  output logic          shift_o,
  output logic          last_o
);
  localparam int DW = cw(CLKDIV);
  localparam logic [DW-1:0] DIV_END = DW'(CLKDIV - 1);
  localparam logic [DW-1:0] ONE_D = DW'(1);
  localparam logic [BW-1:0] ONE_B = BW'(1);
  logic [W-1:0] data_q, data_d;
  logic [BW-1:0] idx_q, idx_d;
  logic [DW-1:0] div_q, div_d;
  assign sdata_o = en_i & data_q[idx_q];
  assign shift_o = en_i & (div_q == DIV_END);
  assign last_o = shift_o & (idx_q == '0);
  // reload on a new phase, otherwise advance the divider and step the bit index on each strobe
  always_comb begin
    data_d = load_i ? data_i : data_q;
    idx_d = load_i ? top_i : (shift_o && idx_q != '0) ? idx_q - ONE_B : idx_q;
    div_d = load_i ? '0 : !en_i ? div_q : shift_o ? '0 : div_q + ONE_D;
  end
  // serializer state registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      data_q <= '0;
      idx_q <= '0;
      div_q <= '0;
    end else begin
      data_q <= data_d;
      idx_q <= idx_d;
      div_q <= div_d;
    end
  end
endmodule

// File: rtl/shiftreg_loader.sv
// shiftreg_loader: loads static then dynamic shift registers serially; SRLOAD_STAT_SKIP_EN skips an unchanged static word
module shiftreg_loader
  import srload_pkg::*;
#(
  parameter int SIZESRSTAT = DEF_SIZESRSTAT,
  parameter int SIZESRDYN = DEF_SIZESRDYN,
  parameter int CLKDIV = DEF_CLKDIV
) (
  input logic CLK,
  input logic RST_N,
  shiftreg_loader_if.slave bus
);
  localparam int MAXW = max2(SIZESRSTAT, SIZESRDYN);
  localparam int BW = cw(MAXW);
  localparam logic [BW-1:0] TOP_STAT = BW'(SIZESRSTAT - 1);
  localparam logic [BW-1:0] TOP_DYN = BW'(SIZESRDYN - 1);
  state_t state_q, state_d;
  logic [SIZESRDYN-1:0] dyn_q;
  logic ld, en, last, skip;
  logic [MAXW-1:0] ld_data;
  logic [BW-1:0] ld_top;
  logic accept;
  assign accept = state_q == IDLE && bus.START;
`ifdef SRLOAD_STAT_SKIP_EN
  logic [SIZESRSTAT-1:0] stat_q, kept_q;
  logic kept_v_q;
  assign skip = kept_v_q && bus.STAT_WORD == kept_q;
  // remember the static word once its latch has actually been pulsed
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stat_q <= '0;
      kept_q <= '0;
      kept_v_q <= 1'b0;
    end else begin
      if (accept) stat_q <= bus.STAT_WORD;
      if (state_q == LAT_STAT) begin
        kept_q <= stat_q;
        kept_v_q <= 1'b1;
      end
    end
  end
`else
  assign skip = 1'b0;
`endif
  // state register
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= IDLE;
    else state_q <= state_d;
  end
  // dynamic word shadow; the static word goes straight into the serializer at acceptance
  always_ff @(posedge CLK) begin
    if (!RST_N) dyn_q <= '0;
    else if (accept) dyn_q <= bus.DYN_WORD;
  end
  // next state and serializer reload selection
  always_comb begin
    state_d = state_q;
    ld = 1'b0;
    en = 1'b0;
    ld_data = MAXW'(bus.STAT_WORD);
    ld_top = TOP_STAT;
    case (state_q)
      IDLE: if (bus.START) begin
        ld = 1'b1;
        state_d = skip ? SH_DYN : SH_STAT;
        ld_data = skip ? MAXW'(bus.DYN_WORD) : MAXW'(bus.STAT_WORD);
        ld_top = skip ? TOP_DYN : TOP_STAT;
      end
      SH_STAT: begin
        en = 1'b1;
        state_d = last ? LAT_STAT : SH_STAT;
      end
      LAT_STAT: begin
        ld = 1'b1;
        ld_data = MAXW'(dyn_q);
        ld_top = TOP_DYN;
        state_d = SH_DYN;
      end
      SH_DYN: begin
        en = 1'b1;
        state_d = last ? LAT_DYN : SH_DYN;
      end
      LAT_DYN: state_d = FIN;
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  srload_serializer #(.W(MAXW), .CLKDIV(CLKDIV), .BW(BW)) u_ser (
    .clk_i(CLK),
    .rst_n_i(RST_N),
    .load_i(ld),
    .data_i(ld_data),
    .top_i(ld_top),
    .en_i(en),
    .sdata_o(bus.SDATA),
    .shift_o(bus.SHIFT),
    .last_o(last)
  );
  assign bus.SELSTAT = state_q == SH_STAT || state_q == LAT_STAT;
  assign bus.SELDYN = state_q == SH_DYN || state_q == LAT_DYN;
  assign bus.LATCH_STAT = state_q == LAT_STAT;
  assign bus.LATCH_DYN = state_q == LAT_DYN;
  assign bus.BUSY = state_q != IDLE;
  assign bus.DONE = state_q == FIN;
endmodule

// File: tb/tb_shiftreg_loader.sv
// tb_shiftreg_loader: directed and random loads checked cycle by cycle against a per-cycle output trace model
module tb_shiftreg_loader;
  import srload_pkg::*;
  localparam int S = 8;
  localparam int Y = 4;
  localparam int D = 2;
`ifdef SRLOAD_STAT_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif
  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;
  shiftreg_loader_if #(.SIZESRSTAT(S), .SIZESRDYN(Y)) bus ();
  shiftreg_loader #(.SIZESRSTAT(S), .SIZESRDYN(Y), .CLKDIV(D)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .bus(bus)
  );
  logic [7:0] obs;
  assign obs = {bus.BUSY, bus.DONE, bus.LATCH_STAT, bus.LATCH_DYN, bus.SELSTAT, bus.SELDYN, bus.SHIFT, bus.SDATA};
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] kept;
  bit kept_v;
  int lstat_cyc, ldyn_cyc, done_cyc, done_cnt, sel_rise, nbits;
  bit sel_seen;
  logic [11:0] bits;
  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] x);
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, x);
    end
  endtask
  task automatic add_word(input logic [7:0] w, input int n, input bit dyn);
    for (int b = n - 1; b >= 0; b--)
      for (int c = 0; c < D; c++)
        exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, !dyn, dyn, c == D - 1, w[b]});
    exp_q.push_back({1'b1, 1'b0, !dyn, dyn, !dyn, dyn, 2'b00});
  endtask
  task automatic build(input logic [7:0] s, input logic [3:0] d);
    bit skip;
    skip = SKIP_EN && kept_v && kept == s;
    if (!skip) begin
      add_word(s, S, 1'b0);
      kept = s;
      kept_v = 1'b1;
    end
    add_word({4'b0, d}, Y, 1'b1);
    exp_q.push_back(8'hC0);
  endtask
  task automatic run(input logic [7:0] s, input logic [3:0] d, input logic [7:0] s2, input bit b2b,
                     input int busy_cyc, input int chg_cyc, input int rst_cyc, input int tail);
    int len1;
    logic [7:0] e, prev;
    exp_q.delete();
    lstat_cyc = 0; ldyn_cyc = 0; done_cyc = 0; done_cnt = 0; sel_rise = 0; nbits = 0; bits = '0; sel_seen = 0;
    @(negedge CLK);
    bus.START = 1'b1;
    bus.STAT_WORD = s;
    bus.DYN_WORD = d;
    @(posedge CLK);
    build(s, d);
    len1 = exp_q.size();
    if (b2b) begin
      exp_q.push_back(8'h00);
      build(s2, d);
    end
    if (rst_cyc > 0) kept_v = 1'b0;
    #1;
    bus.START = b2b;
    if (b2b) bus.STAT_WORD = s2;
    prev = '0;
    for (int k = 1; k <= exp_q.size() + tail; k++) begin
      @(negedge CLK);
      e = (k <= exp_q.size() && !(rst_cyc > 0 && k > rst_cyc)) ? exp_q[k-1] : 8'h00;
      check($sformatf("cyc%0d", k), obs, e);
      if (obs[5] && lstat_cyc == 0) lstat_cyc = k;
      if (obs[4] && ldyn_cyc == 0) ldyn_cyc = k;
      if (obs[6]) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = k;
      end
      if (obs[3]) sel_seen = 1'b1;
      if (k > 1 && obs[3] && !prev[3] && sel_rise == 0) sel_rise = k;
      if (obs[1]) begin
        bits = {bits[10:0], obs[0]};
        nbits++;
      end
      prev = obs;
      bus.START = (k == busy_cyc) || (b2b && k < len1 + 2);
      if (k == chg_cyc) bus.STAT_WORD = 8'hFF;
      if (k == rst_cyc) RST_N = 1'b0;
      if (rst_cyc > 0 && k == rst_cyc + 1) RST_N = 1'b1;
    end
  endtask
  initial begin
    RST_N = 1'b0;
    bus.START = 1'b0;
    bus.STAT_WORD = '0;
    bus.DYN_WORD = '0;
    kept = '0;
    kept_v = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_outputs", obs, 8'h00);
    RST_N = 1'b1;
    run(8'hA5, 4'h9, 8'h00, 1'b0, 0, 0, 0, 3);
    check("basic_latch_stat_cyc", lstat_cyc, 17);
    check("basic_latch_dyn_cyc", ldyn_cyc, 26);
    check("basic_done_cyc", done_cyc, 27);
    check("basic_bits", bits, 12'hA59);
    check("basic_nbits", nbits, 12);
    run(8'hC3, 4'h6, 8'h00, 1'b0, 5, 0, 0, 6);
    check("busy_done_cnt", done_cnt, 1);
    check("busy_done_cyc", done_cyc, 27);
    run(8'h00, 4'hF, 8'h00, 1'b0, 0, 3, 0, 2);
    check("chg_bits", bits, 12'h00F);
    run(8'hFF, 4'h3, 8'h00, 1'b0, 0, 0, 10, 4);
    check("rst_no_latch_stat", lstat_cyc, 0);
    check("rst_no_latch_dyn", ldyn_cyc, 0);
    check("rst_no_done", done_cnt, 0);
    run(8'h81, 4'h1, 8'h7E, 1'b1, 0, 0, 0, 3);
    check("b2b_done_cyc", done_cyc, 27);
    check("b2b_selstat_rise", sel_rise, done_cyc + 2);
    check("b2b_done_cnt", done_cnt, 2);
    repeat (6) run(8'($urandom), 4'($urandom), 8'h00, 1'b0, 0, 0, 0, $urandom_range(0, 3));
`ifdef SRLOAD_STAT_SKIP_EN
    run(8'hC3, 4'h2, 8'h00, 1'b0, 0, 0, 0, 1);
    run(8'h3C, 4'h5, 8'h00, 1'b0, 0, 0, 0, 1);
    check("skip_first_done_cyc", done_cyc, 27);
    run(8'h3C, 4'hA, 8'h00, 1'b0, 0, 0, 0, 2);
    check("skip_done_cyc", done_cyc, 10);
    check("skip_selstat_seen", sel_seen, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shiftreg_loader.md
# shiftreg_loader

Serial configuration loader that sits directly upstream of the square-wave generator and its static/dynamic shift registers. On a start request it snapshots a static word and a dynamic word, shifts each out MSB-first on one serial data line under a bit strobe, and pulses the matching latch once each word is complete. It drives the register-select lines that `fsm_shiftRegs` currently drives, and it reports completion so the generator can enable its output.

## Interface
- `SIZESRSTAT`, default 88: static shift register length in bits (≥1).
- `SIZESRDYN`, default 16: dynamic shift register length in bits (≥1).
- `CLKDIV`, default 4: CLK cycles per serial bit (≥2).
- `CLK` input, 1 bit: system clock; all logic is on the rising edge.
- `RST_N` input, 1 bit: synchronous, active-low reset.
- `START` input, 1 bit: load request, sampled only in IDLE.
- `STAT_WORD` input, `SIZESRSTAT` bits: static configuration word.
- `DYN_WORD` input, `SIZESRDYN` bits: dynamic configuration word.
- `SDATA` output, 1 bit: serial data, held stable for a whole bit period.
- `SHIFT` output, 1 bit: one-cycle strobe on the last cycle of each bit period.
- `SELSTAT` output, 1 bit: static register selected.
- `SELDYN` output, 1 bit: dynamic register selected.
- `LATCH_STAT` output, 1 bit: one-cycle static latch pulse.
- `LATCH_DYN` output, 1 bit: one-cycle dynamic latch pulse.
- `BUSY` output, 1 bit: a load is in progress.
- `DONE` output, 1 bit: one-cycle completion pulse.

## Operation
- **States:** IDLE → SH_STAT → LAT_STAT → SH_DYN → LAT_DYN → FIN → IDLE.
- **IDLE, START=1:** snapshot `STAT_WORD` and `DYN_WORD` into internal shadow registers, then go to SH_STAT. Input changes after the snapshot have no effect on the load in progress.
- **SH_STAT:**
  - `SELSTAT`=1 and `SDATA` = current shadow bit, starting at bit `SIZESRSTAT-1`.
  - A divider counter runs 0..`CLKDIV-1`. `SHIFT`=1 when it equals `CLKDIV-1`, and the bit index then decrements.
  - After the strobe of bit 0, go to LAT_STAT.
- **LAT_STAT:** `LATCH_STAT`=1 and `SELSTAT`=1 for one cycle, then go to SH_DYN.
- **SH_DYN:** identical to SH_STAT, using `SELDYN` and `SIZESRDYN` bits.
- **LAT_DYN:** `LATCH_DYN`=1 and `SELDYN`=1 for one cycle, then go to FIN.
- **FIN:** `DONE`=1 for one cycle, then go to IDLE.
- **`BUSY`:** 1 in every state except IDLE.
- **Ignored requests:** `START` is ignored in every non-IDLE state. It is not queued.
- **Exclusivity:** `SELSTAT` and `SELDYN` are never high together. `SHIFT` never coincides with a latch pulse.
- **`SDATA` outside shift states:** 0.
- **Counter widths:**
  - Bit counter: `$clog2(max(SIZESRSTAT,SIZESRDYN))` bits.
  - Divider: `$clog2(CLKDIV)` bits.
  - Neither wraps. Both reload at the start of each shift phase.

## Timing
- **Reset values:** every output is 0 and the state is IDLE. Reset is synchronous, so it takes effect on the first CLK edge with `RST_N`=0.
- **Reset mid-load:** abort immediately. No latch pulse and no `DONE` are emitted for the aborted load.
- **START accepted at edge t** (cycle numbers are rising edges after t):
  - SH_STAT occupies cycles 1..`88·D`.
  - LAT_STAT is at `88·D+1`.
  - SH_DYN occupies `88·D+2`..`104·D+1`.
  - LAT_DYN is at `104·D+2`.
  - FIN (`DONE`) is at `104·D+3`.
  - With defaults (D=`CLKDIV`=4), `DONE` is at cycle 419.
- **General formula:** `DONE` latency = `(SIZESRSTAT+SIZESRDYN)·CLKDIV + 3` cycles.
- **First `SHIFT`:** cycle `CLKDIV` after acceptance.
- **Back-to-back loads:** a `START` held high through FIN is accepted on the first IDLE cycle. There is no other dead time.

## Configuration
- **Macro `SRLOAD_STAT_SKIP_EN`:**
  - Defined: the block keeps the last fully loaded static word. On an accepted `START` whose `STAT_WORD` equals it, go straight to SH_DYN; `SELSTAT` and `LATCH_STAT` stay 0 and `DONE` latency is `SIZESRDYN·CLKDIV + 2`. The kept word is cleared by reset and is updated only when LAT_STAT completes.
  - Not defined: every load shifts both words.

## Structure
- **Package `srload_pkg`:** state enum (`IDLE`, `SH_STAT`, `LAT_STAT`, `SH_DYN`, `LAT_DYN`, `FIN`) and the default sizes 88/16 shared with the generator.
- **Sub-module `srload_serializer`:** parallel-in, MSB-first serial-out with the bit-period divider and `SHIFT` strobe. It is instantiated once and reloaded per phase.
- **Top FSM:** `shiftreg_loader` holds the FSM, the shadow registers and the latch pulses.

## Test plan
Bench configuration: `SIZESRSTAT`=8, `SIZESRDYN`=4, `CLKDIV`=2.
- **Basic load:** `START` with `STAT_WORD`=0xA5 and `DYN_WORD`=0x9. Bits captured on `SHIFT` read 1,0,1,0,0,1,0,1 then 1,0,0,1; `LATCH_STAT` at cycle 17, `LATCH_DYN` at cycle 26, `DONE` at cycle 27.
- **START while busy:** pulse `START` again at cycle 5. The load is unchanged and only one `DONE` is emitted.
- **Inputs change mid-load:** set `STAT_WORD`=0xFF at cycle 3 during a 0x00 load. All static bits shifted are 0.
- **Reset mid-shift:** `RST_N`=0 at cycle 10. The next cycle has all outputs 0; no `LATCH_*` and no `DONE` appear.
- **Back-to-back:** hold `START`=1 continuously. A second `SELSTAT` rises exactly 2 cycles after `DONE`.
- **`SRLOAD_STAT_SKIP_EN` defined:** load 0x3C twice. The second load has `SELSTAT`=0 throughout and `DONE` 10 cycles after acceptance.
